// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers and default sizes, used by both read and write sides.
package fifo_pkg;

    localparam int unsigned DEF_ADDRSIZE      = 32;
    localparam int unsigned DEF_AEMPTY_THRESH = 4;
    localparam int unsigned PTR_MAX_W         = 64;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR fold; zero-extended upper bits leave narrow pointers intact.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int s = 1; s < int'(PTR_MAX_W); s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer bringing the Gray write pointer into the read clock domain.
module sync_w2r #(
    parameter int unsigned ADDRSIZE = 32
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   rq2_wptr
);

    logic [ADDRSIZE:0] rq1_wptr;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Async FIFO read-pointer and empty-flag logic.
// Define RPTR_LEVEL_EN to build the occupancy (rlevel) and almost-empty (raempty) logic.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE      = DEF_ADDRSIZE,
    parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic                rempty,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                raempty,
    output logic                runderflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic              rd_en;

    sync_w2r #(.ADDRSIZE(ADDRSIZE)) u_sync_w2r (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr     (wptr),
        .rq2_wptr (rq2_wptr)
    );

    // A read while empty is an underflow and must not move the pointer.
    assign rd_en     = rinc & ~rempty;
    assign rbinnext  = rbin + PW'(rd_en);
    assign rgraynext = PW'(bin2gray(ptr_max_t'(rbinnext)));
    assign raddr     = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            rempty     <= (rgraynext == rq2_wptr);
            runderflow <= runderflow | (rinc & rempty);
        end
    end

`ifdef RPTR_LEVEL_EN
    logic [ADDRSIZE:0] wq2_bin;
    logic [ADDRSIZE:0] level_next;

    assign wq2_bin    = PW'(gray2bin(ptr_max_t'(rq2_wptr)));
    assign level_next = wq2_bin - rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel  <= '0;
            raempty <= 1'b1;
        end else begin
            rlevel  <= level_next;
            raempty <= (level_next <= PW'(AEMPTY_THRESH));
        end
    end
`else
    assign rlevel  = '0;
    assign raempty = rempty;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty (ADDRSIZE=4, AEMPTY_THRESH=4) against a count-based model.
module tb_rptr_empty;

    localparam int unsigned AW  = 4;
    localparam int          MOD = 32;
    localparam int          THR = 4;

    logic          clk    = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rinc   = 1'b0;
    logic [AW:0]   wptr;
    logic          rempty;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic [AW:0]   rlevel;
    logic          raempty;
    logic          runderflow;

    int wcount = 0;
    int total  = 0;
    int bad    = 0;
    bit chk_en = 1'b0;

    function automatic logic [AW:0] gray5(input int n);
        logic [AW:0] b;
        b = 5'(n % MOD);
        return b ^ (b >> 1);
    endfunction

    assign wptr = gray5(wcount);

    rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(THR)) dut (
        .rclk       (clk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .wptr       (wptr),
        .rempty     (rempty),
        .raddr      (raddr),
        .rptr       (rptr),
        .rlevel     (rlevel),
        .raempty    (raempty),
        .runderflow (runderflow)
    );

    always #5 clk = ~clk;

    // Model: total words written/read as plain counts; write count seen after two read clocks.
    int m_r     = 0;
    int m_s1    = 0;
    int m_s2    = 0;
    bit m_empty = 1'b1;
    int m_level = 0;
    bit m_uf    = 1'b0;
    int m_rn;
    assign m_rn = m_r + ((rinc && !m_empty) ? 1 : 0);

    always @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_r <= 0; m_s1 <= 0; m_s2 <= 0;
            m_empty <= 1'b1; m_level <= 0; m_uf <= 1'b0;
        end else begin
            m_r     <= m_rn;
            m_empty <= (m_s2 - m_rn) == 0;
            m_level <= (m_s2 - m_rn) % MOD;
            m_uf    <= m_uf || (rinc && m_empty);
            m_s1    <= wcount;
            m_s2    <= m_s1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rempty", int'(rempty), int'(m_empty));
            chk("m_rptr", int'(rptr), int'(gray5(m_r)));
            chk("m_raddr", int'(raddr), m_r % 16);
            chk("m_runderflow", int'(runderflow), int'(m_uf));
`ifdef RPTR_LEVEL_EN
            chk("m_rlevel", int'(rlevel), m_level);
            chk("m_raempty", int'(raempty), int'(m_level <= THR));
`else
            chk("m_rlevel", int'(rlevel), 0);
            chk("m_raempty", int'(raempty), int'(m_empty));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rempty"}, int'(rempty), 1);
        chk({tag, "_rptr"}, int'(rptr), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_rlevel"}, int'(rlevel), 0);
        chk({tag, "_raempty"}, int'(raempty), 1);
        chk({tag, "_runderflow"}, int'(runderflow), 0);
    endtask

    initial begin
        cyc(2);
        chk_en = 1'b1;
        chk_reset_vals("reset");
        rrst_n = 1'b1;

        // Latency: first word visible on the third edge after wptr moves.
        wcount = 1;
        cyc(2);
        chk("lat_rempty_e2", int'(rempty), 1);
        cyc(1);
        chk("lat_rempty_e3", int'(rempty), 0);
`ifdef RPTR_LEVEL_EN
        chk("lat_rlevel", int'(rlevel), 1);
        chk("lat_raempty", int'(raempty), 1);
`else
        chk("lat_rlevel", int'(rlevel), 0);
        chk("lat_raempty", int'(raempty), 0);
`endif

        // Drain sixteen words.
        wcount = 16;
        cyc(3);
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_raddr", int'(raddr), i);
            cyc(1);
        end
        chk("drain_rempty", int'(rempty), 1);
        chk("drain_rptr", int'(rptr), 5'b11000);
        chk("drain_rlevel", int'(rlevel), 0);

        // Underflow: pointer frozen, flag sticky.
        cyc(1);
        chk("uf_flag", int'(runderflow), 1);
        chk("uf_rptr", int'(rptr), 5'b11000);
        rinc = 1'b0;
        cyc(3);
        chk("uf_sticky", int'(runderflow), 1);

        // Wrap: read pointer at 30, write pointer wraps to 34 and 35.
        wcount = 30;
        cyc(3);
        rinc = 1'b1;
        cyc(14);
        rinc = 1'b0;
        chk("wrap_rempty30", int'(rempty), 1);
        chk("wrap_raddr30", int'(raddr), 14);
        wcount = 34;
        cyc(3);
        chk("wrap_rempty34", int'(rempty), 0);
`ifdef RPTR_LEVEL_EN
        chk("wrap_rlevel4", int'(rlevel), 4);
        chk("wrap_raempty4", int'(raempty), 1);
`else
        chk("wrap_rlevel4", int'(rlevel), 0);
        chk("wrap_raempty4", int'(raempty), 0);
`endif
        wcount = 35;
        cyc(3);
`ifdef RPTR_LEVEL_EN
        chk("wrap_rlevel5", int'(rlevel), 5);
`else
        chk("wrap_rlevel5", int'(rlevel), 0);
`endif
        chk("wrap_raempty5", int'(raempty), 0);
        rinc = 1'b1;
        cyc(5);
        rinc = 1'b0;
        chk("wrap_raddr35", int'(raddr), 3);
        chk("wrap_rptr35", int'(rptr), int'(5'b00010));

        // Mid-burst async reset, no clock edge in between.
        wcount = 40;
        cyc(3);
        rinc = 1'b1;
        cyc(3);
        rrst_n = 1'b0;
        wcount = 0;
        #1;
        chk_reset_vals("async");
        cyc(2);
        rrst_n = 1'b1;
        rinc   = 1'b0;
        wcount = 3;
        cyc(3);
        chk("post_raddr0", int'(raddr), 0);
        chk("post_rempty", int'(rempty), 0);
        rinc = 1'b1;
        cyc(1);
        rinc = 1'b0;
        chk("post_raddr1", int'(raddr), 1);
        cyc(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 32, FIFO address width (depth 2^ADDRSIZE).
REQ-002 SHALL have parameter AEMPTY_THRESH, default 4, almost-empty level threshold.
REQ-003 SHALL have port rclk  input  1  read-domain clock; the block uses this one clock only.
REQ-004 SHALL have port rrst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rinc  input  1  read request from consumer.
REQ-006 SHALL have port wptr  input  ADDRSIZE+1  Gray write pointer from write domain, unsynchronized.
REQ-007 SHALL have port rempty  output  1  FIFO empty, registered.
REQ-008 SHALL have port raddr  output  ADDRSIZE  binary memory read address.
REQ-009 SHALL have port rptr  output  ADDRSIZE+1  Gray read pointer, registered, to write domain.
REQ-010 SHALL have port rlevel  output  ADDRSIZE+1  read-side occupancy, registered.
REQ-011 SHALL have port raempty  output  1  almost empty, registered.
REQ-012 SHALL have port runderflow  output  1  sticky underflow error.

Function
REQ-013 SHALL synchronize wptr into rclk domain through two flops (rq2_wptr); no other logic between flops.
REQ-014 SHALL hold binary pointer rbin (ADDRSIZE+1 bits); rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-015 SHALL compute rgraynext = (rbinnext>>1) ^ rbinnext; rbin and rptr update together on each rclk edge.
REQ-016 SHALL drive raddr = rbin[ADDRSIZE-1:0].
REQ-017 SHALL register rempty = (rgraynext == rq2_wptr); asserts on the edge consuming the last word, zero bubble.
REQ-018 SHALL deassert rempty no earlier than the 3rd rclk edge after wptr changes (2 sync + 1 register); pessimistic, never optimistic.
REQ-019 SHALL convert rq2_wptr to binary wq2_bin by XOR-fold, and register rlevel = wq2_bin - rbinnext, modulo 2^(ADDRSIZE+1).
REQ-020 SHALL register raempty = (level value loaded into rlevel <= AEMPTY_THRESH).
REQ-021 SHALL treat rinc while rempty=1 as underflow: pointers unchanged, runderflow set on next edge and held until reset.
REQ-022 SHALL handle pointer wrap (MSB toggle) with no special case; level and empty stay correct across wrap.
REQ-023 SHALL give rlevel max value 2^ADDRSIZE (full) and never exceed it for legal writer behaviour.

Reset
REQ-024 SHALL on rrst_n low, immediately and without clock: rbin=0, rptr=0, sync flops=0, rempty=1, rlevel=0, raempty=1, runderflow=0; raddr=0 follows.
REQ-025 SHALL allow reset mid-burst; first read after release returns address 0.

Configuration
REQ-026 SHALL with macro RPTR_LEVEL_EN defined implement rlevel and raempty per REQ-019/020.
REQ-027 SHALL without RPTR_LEVEL_EN omit gray-to-binary and level logic, drive rlevel=0 and raempty=rempty; ports remain.

Structure
REQ-028 SHALL place bin2gray/gray2bin functions and the default ADDRSIZE/AEMPTY_THRESH constants in shared package fifo_pkg, shared with the write side.
REQ-029 SHALL instance sub-module sync_w2r (parameter ADDRSIZE, rclk, rrst_n, wptr in, rq2_wptr out) for the 2-flop synchronizer.

Verification (ADDRSIZE=4, AEMPTY_THRESH=4)
REQ-030 SHALL check reset: rrst_n=0 -> rempty=1, rptr=5'b00000, raddr=0, rlevel=0, raempty=1, runderflow=0.
REQ-031 SHALL check latency: wptr 0->5'b00001 -> rempty 1->0 at 3rd rclk edge, rlevel=1, raempty=1.
REQ-032 SHALL check drain: wptr=5'b11000 (bin 16), rinc held 16 cycles -> raddr 0..15, rptr ends 5'b11000, rempty=1 on 16th edge, rlevel=0.
REQ-033 SHALL check underflow: rinc=1 with rempty=1 -> rptr unchanged, runderflow=1 next edge, stays 1 until reset.
REQ-034 SHALL check wrap: rbin=30, wq2_bin=2 -> rlevel=4, raempty=1; wq2_bin=3 -> rlevel=5, raempty=0.
REQ-035 SHALL check async reset mid-burst and macro-off build: outputs reach reset values without clock; RPTR_LEVEL_EN undefined -> rlevel=0, raempty tracks rempty.
